// File: rtl/gray_step_ctrl.sv
// Gray-code position sequencer: steps gray_out up/down by a latched count at a
// latched rate. Stepping is done in binary so only one output bit toggles per step.
module gray_step_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  dir,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic [STEP_WIDTH-1:0] steps,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] gray_out,
    output logic                  step_tick,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t                state;
    logic                  dir_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  prescaler;
    logic [STEP_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] bin_cur;
    logic [DATA_WIDTH-1:0] gray_next;

    function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Wrap-around is the natural modulo of the binary add/subtract.
    assign bin_cur   = gray2bin(gray_out);
    assign gray_next = bin2gray(dir_q ? bin_cur + DATA_WIDTH'(1) : bin_cur - DATA_WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            gray_out  <= '0;
            prescaler <= '0;
            remaining <= '0;
            dir_q     <= 1'b0;
            div_q     <= '0;
            step_tick <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        gray_out <= bin2gray(load_val);
                    end else if (start) begin
                        dir_q     <= dir;
                        div_q     <= div;
                        remaining <= steps;
                        prescaler <= '0;
                        if (steps == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Priority: stop, then pause, then a due step.
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (pause) begin
                        state <= S_PAUSE;
                    end else if (prescaler == div_q) begin
                        gray_out  <= gray_next;
                        step_tick <= 1'b1;
                        prescaler <= '0;
                        remaining <= remaining - STEP_WIDTH'(1);
                        if (remaining == STEP_WIDTH'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        prescaler <= prescaler + DIV_WIDTH'(1);
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (!pause) begin
                        state <= S_RUN;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed-vector bench for gray_step_ctrl (DATA_WIDTH=4) with hand-computed
// expected gray positions, busy/done/step_tick timing and reset behaviour.
module tb_gray_step_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop, pause, dir, load;
    logic [7:0] div, steps;
    logic [3:0] load_val;
    logic [3:0] gray_out;
    logic       step_tick, busy, done;

    int n_vec = 0;
    int n_err = 0;

    gray_step_ctrl #(.DATA_WIDTH(4), .DIV_WIDTH(8), .STEP_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .dir(dir), .div(div), .steps(steps), .load(load), .load_val(load_val),
        .gray_out(gray_out), .step_tick(step_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic b, input logic d);
        chk({tag, ".gray"}, 32'(gray_out), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic d, input logic [7:0] dv, input logic [7:0] st);
        start = 1'b1; dir = d; div = dv; steps = st;
        tick();
        start = 1'b0;
    endtask

    logic [3:0] g_exp;

    initial begin
        reset = 1'b1; start = 0; stop = 0; pause = 0; dir = 0; load = 0;
        div = 0; steps = 0; load_val = 0;
        #2;
        expect_out("rst", 4'b0000, 1'b0, 1'b0);
        chk("rst.tick", 32'(step_tick), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // up 3 steps, div=1, from 0
        do_start(1'b1, 8'd1, 8'd3);
        expect_out("a.k", 4'b0000, 1'b1, 1'b0);
        tick(); expect_out("a.k1", 4'b0000, 1'b1, 1'b0);
        tick(); expect_out("a.k2", 4'b0001, 1'b1, 1'b0);
        chk("a.k2.tick", 32'(step_tick), 32'd1);
        tick(); expect_out("a.k3", 4'b0001, 1'b1, 1'b0);
        chk("a.k3.tick", 32'(step_tick), 32'd0);
        tick(); expect_out("a.k4", 4'b0011, 1'b1, 1'b0);
        tick(); expect_out("a.k5", 4'b0011, 1'b1, 1'b0);
        tick(); expect_out("a.k6", 4'b0010, 1'b0, 1'b1);
        tick(); expect_out("a.k7", 4'b0010, 1'b0, 1'b0);

        // down from 0 wraps to all-ones
        do_load(4'b0000);
        expect_out("b.ld", 4'b0000, 1'b0, 1'b0);
        do_start(1'b0, 8'd0, 8'd2);
        expect_out("b.k", 4'b0000, 1'b1, 1'b0);
        tick(); expect_out("b.k1", 4'b1000, 1'b1, 1'b0);
        tick(); expect_out("b.k2", 4'b1001, 1'b0, 1'b1);
        tick(); expect_out("b.k3", 4'b1001, 1'b0, 1'b0);

        // up from all-ones wraps to 0
        do_load(4'b1111);
        expect_out("c.ld", 4'b1000, 1'b0, 1'b0);
        do_start(1'b1, 8'd0, 8'd1);
        tick(); expect_out("c.k1", 4'b0000, 1'b0, 1'b1);
        tick(); expect_out("c.k2", 4'b0000, 1'b0, 1'b0);

        // pause held for 5 edges mid-run: steps land at cycles 4,14,18,22
        do_start(1'b1, 8'd3, 8'd4);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            pause = (cyc >= 6 && cyc <= 10);
            tick();
            if (cyc < 4)       g_exp = 4'b0000;
            else if (cyc < 14) g_exp = 4'b0001;
            else if (cyc < 18) g_exp = 4'b0011;
            else if (cyc < 22) g_exp = 4'b0010;
            else               g_exp = 4'b0110;
            expect_out($sformatf("d.c%0d", cyc), g_exp, cyc < 22, cyc == 22);
        end
        pause = 1'b0;

        // stop on the edge a step is due
        do_start(1'b1, 8'd1, 8'd3);
        tick(); expect_out("e.k1", 4'b0110, 1'b1, 1'b0);
        stop = 1'b1;
        tick(); expect_out("e.k2", 4'b0110, 1'b0, 1'b0);
        chk("e.k2.tick", 32'(step_tick), 32'd0);
        stop = 1'b0;
        tick(); expect_out("e.k3", 4'b0110, 1'b0, 1'b0);
        tick(); expect_out("e.k4", 4'b0110, 1'b0, 1'b0);

        // zero-step start goes straight to DONE
        do_start(1'b1, 8'd0, 8'd0);
        expect_out("f.k", 4'b0110, 1'b0, 1'b1);
        tick(); expect_out("f.k1", 4'b0110, 1'b0, 1'b0);

        // load beats start in the same cycle
        start = 1'b1; load = 1'b1; load_val = 4'b0011; dir = 1'b1; div = 8'd0; steps = 8'd2;
        tick();
        start = 1'b0; load = 1'b0;
        expect_out("g.k", 4'b0010, 1'b0, 1'b0);
        tick(); expect_out("g.k1", 4'b0010, 1'b0, 1'b0);
        tick(); expect_out("g.k2", 4'b0010, 1'b0, 1'b0);

        // async reset after two steps: bin 3 -> 4 -> 5
        do_start(1'b1, 8'd0, 8'd5);
        tick(); expect_out("h.k1", 4'b0110, 1'b1, 1'b0);
        tick(); expect_out("h.k2", 4'b0111, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        expect_out("h.rst", 4'b0000, 1'b0, 1'b0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out($sformatf("h.post%0d", i), 4'b0000, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
